// File: rtl/instr_cache_refill_ctrl.sv
// Refill/invalidate sequencer for a single-line instruction cache: tag/valid
// tracking, hit detection, and beat-by-beat line refill into the data array.
module instr_cache_refill_ctrl #(
    parameter int ADDR_WIDTH  = 5,
    parameter int QWORD_COUNT = 2 ** (ADDR_WIDTH - 2),
    parameter int TAG_WIDTH   = 32 - (ADDR_WIDTH + 2)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   req_i,
    input  logic [31:0]            addr_i,
    output logic                   hit_o,
    output logic                   ready_o,
    output logic                   stall_o,
    output logic                   err_o,
    input  logic                   invalidate_i,
    output logic                   mem_req_valid_o,
    input  logic                   mem_req_ready_i,
    output logic [31:0]            mem_addr_o,
    input  logic                   mem_rsp_valid_i,
    input  logic [127:0]           mem_rsp_data_i,
    input  logic                   mem_rsp_err_i,
    output logic [127:0]           cache_flush_data_o,
    output logic [QWORD_COUNT-1:0] cache_flushing_n_o
);

    localparam int BW = ADDR_WIDTH - 2;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t               state;
    logic                 valid_q;
    logic                 kill_q;
    logic [TAG_WIDTH-1:0] tag_q;
    logic [TAG_WIDTH-1:0] base_q;
    logic [BW-1:0]        beat_q;

    logic [TAG_WIDTH-1:0] addr_tag;
    logic                 rsp_ok;
    logic                 unused_addr_bits;

    assign addr_tag         = addr_i[31:ADDR_WIDTH+2];
    assign unused_addr_bits = ^addr_i[ADDR_WIDTH+1:0];

    assign hit_o   = valid_q && (tag_q == addr_tag);
    assign ready_o = req_i && hit_o && (state == IDLE);
    assign stall_o = req_i && !ready_o;

    assign rsp_ok = (state == WAIT) && mem_rsp_valid_i && !mem_rsp_err_i;
    assign err_o  = (state == WAIT) && mem_rsp_valid_i && mem_rsp_err_i;

    assign mem_req_valid_o    = (state == REQ);
    assign mem_addr_o         = (state == REQ) ? {base_q, beat_q, 4'b0000} : 32'h0;
    assign cache_flush_data_o = mem_rsp_data_i;

    always_comb begin
        cache_flushing_n_o = '1;
        if (rsp_ok) cache_flushing_n_o[beat_q] = 1'b0;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state   <= IDLE;
            valid_q <= 1'b0;
            kill_q  <= 1'b0;
            beat_q  <= '0;
            tag_q   <= '0;
            base_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // Invalidate wins over a miss starting in the same cycle.
                    if (invalidate_i) begin
                        valid_q <= 1'b0;
                    end else if (req_i && !hit_o) begin
                        base_q  <= addr_tag;
                        beat_q  <= '0;
                        valid_q <= 1'b0;
                        state   <= REQ;
                    end
                end
                REQ: begin
                    if (invalidate_i) kill_q <= 1'b1;
                    if (mem_req_ready_i) state <= WAIT;
                end
                WAIT: begin
                    if (invalidate_i) kill_q <= 1'b1;
                    if (mem_rsp_valid_i) begin
                        if (mem_rsp_err_i) begin
                            kill_q <= 1'b0;
                            state  <= IDLE;
                        end else if (beat_q == BW'(QWORD_COUNT - 1)) begin
                            state <= DONE;
                        end else begin
                            beat_q <= beat_q + 1'b1;
                            state  <= REQ;
                        end
                    end
                end
                DONE: begin
                    // A fence.i seen at any point during the refill leaves the line invalid.
                    tag_q   <= base_q;
                    valid_q <= !(kill_q || invalidate_i);
                    kill_q  <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
